// File: rtl/ssram_ws.sv
// Single-port SRAM target with a fixed-latency wait-state pipeline and an in-order, credit-limited response FIFO.
// Byte/half/word writes; reserved-size, misaligned or out-of-range accesses answer with rerr/werr.
module ssram_ws #(
   parameter logic [31:0] C_BASE_ADDR   = 32'h0,
   parameter int          C_DEPTH       = 4096,
   parameter int          C_WAIT_STATES = 0,
   parameter int          C_RSP_DEPTH   = 2
) (
   input  logic        clk_i,
   input  logic        resetb_i,
   input  logic        clk_en_i,
   output logic        treqready_o,
   input  logic        treqvalid_i,
   input  logic        treqdvalid_i,
   input  logic [1:0]  treqsize_i,
   input  logic [31:0] treqaddr_i,
   input  logic [31:0] treqdata_i,
   input  logic        trspready_i,
   output logic        trspvalid_o,
   output logic        trsprerr_o,
   output logic        trspwerr_o,
   output logic [31:0] trspdata_o
);
   localparam int          LP_AW   = $clog2(C_DEPTH);
   localparam int          LP_PW   = (C_RSP_DEPTH > 1) ? $clog2(C_RSP_DEPTH) : 1;
   localparam int          LP_OW   = $clog2(C_RSP_DEPTH + 1);
   localparam logic [32:0] LP_SPAN = 33'(C_DEPTH) << 2;

   logic [31:0]            r_mem [C_DEPTH];
   logic                   r_live;
   logic [LP_OW-1:0]       r_outst;
   logic [LP_OW-1:0]       r_fcnt;
   logic [LP_PW-1:0]       r_wptr;
   logic [LP_PW-1:0]       r_rptr;
   logic [31:0]            r_fdat [C_RSP_DEPTH];
   logic [C_RSP_DEPTH-1:0] r_frerr;
   logic [C_RSP_DEPTH-1:0] r_fwerr;

   logic [32:0]      w_off;
   logic [LP_AW-1:0] w_idx;
   logic             w_err;
   logic [3:0]       w_be;
   logic             w_acc;
   logic             w_pop;
   logic [31:0]      w_rsp_dat;
   logic             w_rsp_rerr;
   logic             w_rsp_werr;
   logic             w_in_vld;
   logic [31:0]      w_in_dat;
   logic             w_in_rerr;
   logic             w_in_werr;
   logic [LP_PW-1:0] w_wnext;
   logic [LP_PW-1:0] w_rnext;

   assign treqready_o = r_live & (r_outst < LP_OW'(C_RSP_DEPTH));
   assign trspvalid_o = (r_fcnt != '0);
   assign w_acc       = resetb_i & clk_en_i & treqvalid_i & treqready_o;
   assign w_pop       = resetb_i & clk_en_i & trspvalid_o & trspready_i;

   // 33-bit offset: an address below the base borrows into bit 32 and fails the span test.
   assign w_off = {1'b0, treqaddr_i} - {1'b0, C_BASE_ADDR};
   assign w_idx = w_off[LP_AW+1:2];

   always_comb begin
      w_err = 1'b0;
      case (treqsize_i)
         2'd1:    w_err = treqaddr_i[0];
         2'd2:    w_err = (treqaddr_i[1:0] != 2'b00);
         2'd3:    w_err = 1'b1;
         default: w_err = 1'b0;
      endcase
      if (w_off >= LP_SPAN) w_err = 1'b1;
   end

   always_comb begin
      w_be = 4'b0000;
      case (treqsize_i)
         2'd0:    w_be = 4'b0001 << treqaddr_i[1:0];
         2'd1:    w_be = treqaddr_i[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_acc && treqdvalid_i && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= treqdata_i[8*b +: 8];
         end
      end
   end

   assign w_rsp_dat  = (treqdvalid_i | w_err) ? 32'h0 : r_mem[w_idx];
   assign w_rsp_rerr = w_err & ~treqdvalid_i;
   assign w_rsp_werr = w_err & treqdvalid_i;

   generate
      if (C_WAIT_STATES == 0) begin : g_nows
         assign w_in_vld  = w_acc;
         assign w_in_dat  = w_rsp_dat;
         assign w_in_rerr = w_rsp_rerr;
         assign w_in_werr = w_rsp_werr;
      end else begin : g_ws
         logic [C_WAIT_STATES-1:0] r_pv;
         logic [C_WAIT_STATES-1:0] r_prerr;
         logic [C_WAIT_STATES-1:0] r_pwerr;
         logic [31:0]              r_pdat [C_WAIT_STATES];

         always_ff @(posedge clk_i) begin
            if (!resetb_i) begin
               r_pv <= '0;
            end else if (clk_en_i) begin
               r_pv[0]    <= w_acc;
               r_pdat[0]  <= w_rsp_dat;
               r_prerr[0] <= w_rsp_rerr;
               r_pwerr[0] <= w_rsp_werr;
               for (int s = 1; s < C_WAIT_STATES; s++) begin
                  r_pv[s]    <= r_pv[s-1];
                  r_pdat[s]  <= r_pdat[s-1];
                  r_prerr[s] <= r_prerr[s-1];
                  r_pwerr[s] <= r_pwerr[s-1];
               end
            end
         end

         assign w_in_vld  = r_pv[C_WAIT_STATES-1];
         assign w_in_dat  = r_pdat[C_WAIT_STATES-1];
         assign w_in_rerr = r_prerr[C_WAIT_STATES-1];
         assign w_in_werr = r_pwerr[C_WAIT_STATES-1];
      end
   endgenerate

   assign w_wnext = (r_wptr == LP_PW'(C_RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
   assign w_rnext = (r_rptr == LP_PW'(C_RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

   // The outstanding credit covers pipeline plus FIFO, so a push never finds the FIFO full.
   always_ff @(posedge clk_i) begin
      if (!resetb_i) begin
         r_live  <= 1'b0;
         r_outst <= '0;
         r_fcnt  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else if (clk_en_i) begin
         r_live <= 1'b1;
         if (w_in_vld) begin
            r_fdat[r_wptr]  <= w_in_dat;
            r_frerr[r_wptr] <= w_in_rerr;
            r_fwerr[r_wptr] <= w_in_werr;
            r_wptr          <= w_wnext;
         end
         if (w_pop) r_rptr <= w_rnext;
         case ({w_in_vld, w_pop})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: r_fcnt <= r_fcnt;
         endcase
         case ({w_acc, w_pop})
            2'b10:   r_outst <= r_outst + 1'b1;
            2'b01:   r_outst <= r_outst - 1'b1;
            default: r_outst <= r_outst;
         endcase
      end
   end

   assign trspdata_o = trspvalid_o ? r_fdat[r_rptr] : 32'h0;
   assign trsprerr_o = trspvalid_o & r_frerr[r_rptr];
   assign trspwerr_o = trspvalid_o & r_fwerr[r_rptr];
endmodule

// File: tb/tb_ssram_ws.sv
// Directed plus random traffic against a queue/array reference model of the SRAM target;
// every cycle checks ready/valid and the head response fields.
module tb_ssram_ws;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 64;
   localparam int          WS    = 2;
   // A slot frees only the cycle after its pop, so back-to-back traffic needs WS+2 slots.
   localparam int          RD    = WS + 2;

   typedef struct {
      logic [31:0] dat;
      logic        rerr;
      logic        werr;
      int          due;
   } rsp_t;

   logic        clk = 1'b0;
   logic        resetb, clk_en;
   logic        treqready, treqvalid, treqdvalid;
   logic [1:0]  treqsize;
   logic [31:0] treqaddr, treqdata;
   logic        trspready, trspvalid, trsprerr, trspwerr;
   logic [31:0] trspdata;

   int          checks = 0, errors = 0;
   int          ecnt = 0, accs = 0, pops = 0, acc_cyc = 0, pop_cyc = 0;
   logic        acc_f = 1'b0;
   logic        m_live = 1'b0;
   logic [31:0] p_dat;
   logic        p_rerr, p_werr;
   logic [31:0] m_mem [DEPTH];
   rsp_t        q[$];

   ssram_ws #(
      .C_BASE_ADDR(BASE), .C_DEPTH(DEPTH), .C_WAIT_STATES(WS), .C_RSP_DEPTH(RD)
   ) u_dut (
      .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
      .treqready_o(treqready), .treqvalid_i(treqvalid), .treqdvalid_i(treqdvalid),
      .treqsize_i(treqsize), .treqaddr_i(treqaddr), .treqdata_i(treqdata),
      .trspready_i(trspready), .trspvalid_o(trspvalid), .trsprerr_o(trsprerr),
      .trspwerr_o(trspwerr), .trspdata_o(trspdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: an access of 2**sz bytes must be size-aligned and lie wholly inside the window.
   function automatic void model(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, output rsp_t r);
      longint unsigned ua, lo, hi, nb;
      int              idx, lane;
      logic            err;
      ua  = 64'(a);
      lo  = 64'(BASE);
      hi  = lo + 64'(4 * DEPTH);
      nb  = 64'd1 << sz;
      err = (sz == 2'd3) || (ua < lo) || (ua >= hi) || ((ua % nb) != 0);
      r.dat  = 32'h0;
      r.rerr = err & ~wr;
      r.werr = err & wr;
      r.due  = 0;
      if (!err) begin
         idx = int'((ua - lo) / 64'd4);
         if (wr) begin
            for (longint unsigned k = 0; k < nb; k++) begin
               lane = int'((ua % 64'd4) + k);
               m_mem[idx][8*lane +: 8] = d[8*lane +: 8];
            end
         end else begin
            r.dat = m_mem[idx];
         end
      end
   endfunction

   task automatic cyc();
      logic e_vld, e_rdy, m_acc, m_pop;
      rsp_t r;
      #1;
      e_vld = 1'b0;
      if (q.size() > 0) e_vld = (ecnt >= q[0].due);
      e_rdy = m_live && (q.size() < RD);
      chk("treqready", 32'(treqready), 32'(e_rdy));
      chk("trspvalid", 32'(trspvalid), 32'(e_vld));
      if (e_vld) begin
         chk("trspdata", trspdata, q[0].dat);
         chk("trsprerr", 32'(trsprerr), 32'(q[0].rerr));
         chk("trspwerr", 32'(trspwerr), 32'(q[0].werr));
      end else if (!m_live) begin
         chk("rst_data", trspdata, 32'h0);
         chk("rst_rerr", 32'(trsprerr), 32'h0);
         chk("rst_werr", 32'(trspwerr), 32'h0);
      end
      m_acc = treqvalid && e_rdy && clk_en && resetb;
      m_pop = e_vld && trspready && clk_en && resetb;
      acc_f = m_acc;
      if (m_acc) begin
         acc_cyc = ecnt;
         accs++;
         model(treqdvalid, treqsize, treqaddr, treqdata, r);
      end
      if (trspvalid === 1'b1 && trspready && clk_en && resetb) begin
         pops++;
         pop_cyc = ecnt;
         p_dat   = trspdata;
         p_rerr  = trsprerr;
         p_werr  = trspwerr;
      end
      @(posedge clk);
      if (!resetb) begin
         q.delete();
         m_live = 1'b0;
      end else if (clk_en) begin
         ecnt++;
         m_live = 1'b1;
         if (m_pop) void'(q.pop_front());
         if (m_acc) begin
            r.due = ecnt + WS;
            q.push_back(r);
         end
      end
      @(negedge clk);
   endtask

   task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      treqvalid = 1'b1; treqdvalid = wr; treqsize = sz; treqaddr = a; treqdata = d;
      do begin
         cyc();
         n++;
      end while (!acc_f && n < 50);
      treqvalid = 1'b0;
      chk("req_accepted", 32'(acc_f), 32'd1);
   endtask

   task automatic wait_rsp();
      int n0 = pops;
      int n  = 0;
      trspready = 1'b1;
      while (pops == n0 && n < 50) begin
         cyc();
         n++;
      end
      chk("rsp_arrived", 32'(pops - n0), 32'd1);
   endtask

   initial begin
      int t_acc, a0, p0;
      resetb = 1'b0; clk_en = 1'b1; treqvalid = 1'b0; treqdvalid = 1'b0;
      treqsize = 2'd0; treqaddr = 32'h0; treqdata = 32'h0; trspready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc();
      resetb = 1'b1;
      cyc();
      repeat (3) cyc();

      trspready = 1'b1;
      for (int i = 0; i < DEPTH; i++) req(1'b1, 2'd2, BASE + 32'(4 * i), $urandom());
      repeat (WS + 3) cyc();

      req(1'b1, 2'd2, BASE + 32'd8, 32'hDEAD_BEEF);
      req(1'b0, 2'd2, BASE + 32'd8, 32'h0);
      t_acc = acc_cyc;
      wait_rsp();
      chk("wr_werr", 32'(p_werr), 32'h0);
      wait_rsp();
      chk("rd_data", p_dat, 32'hDEAD_BEEF);
      chk("rd_rerr", 32'(p_rerr), 32'h0);
      chk("rd_latency", 32'(pop_cyc - t_acc), 32'(WS + 1));

      req(1'b1, 2'd0, BASE + 32'd9, 32'h0000_5500);  wait_rsp();
      req(1'b0, 2'd2, BASE + 32'd8, 32'h0);          wait_rsp();
      chk("byte_wr", p_dat, 32'hDEAD_55EF);
      req(1'b1, 2'd1, BASE + 32'd10, 32'h1234_0000); wait_rsp();
      req(1'b0, 2'd2, BASE + 32'd8, 32'h0);          wait_rsp();
      chk("half_wr", p_dat, 32'h1234_55EF);

      req(1'b0, 2'd2, BASE + 32'd2, 32'h0);                  wait_rsp();
      chk("mis_rerr", 32'(p_rerr), 32'h1);
      chk("mis_data", p_dat, 32'h0);
      req(1'b1, 2'd2, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF); wait_rsp();
      chk("oor_hi_werr", 32'(p_werr), 32'h1);
      req(1'b1, 2'd2, BASE - 32'd4, 32'hFFFF_FFFF);          wait_rsp();
      chk("oor_lo_werr", 32'(p_werr), 32'h1);
      req(1'b1, 2'd3, BASE + 32'd8, 32'hFFFF_FFFF);          wait_rsp();
      chk("size3_werr", 32'(p_werr), 32'h1);
      req(1'b1, 2'd1, BASE + 32'd9, 32'hFFFF_FFFF);          wait_rsp();
      chk("mis_half_werr", 32'(p_werr), 32'h1);
      req(1'b0, 2'd3, BASE + 32'd8, 32'h0);                  wait_rsp();
      chk("size3_rerr", 32'(p_rerr), 32'h1);
      req(1'b0, 2'd2, BASE + 32'(4 * DEPTH - 4), 32'h0);     wait_rsp();
      chk("last_word_rerr", 32'(p_rerr), 32'h0);
      req(1'b0, 2'd2, BASE + 32'd8, 32'h0);                  wait_rsp();
      chk("mem_unchanged", p_dat, 32'h1234_55EF);

      a0 = accs;
      trspready = 1'b0; treqvalid = 1'b1; treqdvalid = 1'b0; treqsize = 2'd2;
      for (int i = 0; i < RD + 2; i++) begin
         treqaddr = BASE + 32'(4 * i);
         cyc();
      end
      chk("full_accepts", 32'(accs - a0), 32'(RD));
      chk("full_rdy", 32'(treqready), 32'h0);
      trspready = 1'b1;
      p0 = pops;
      cyc();
      treqvalid = 1'b0;
      chk("rdy_after_pop", 32'(treqready), 32'h1);
      repeat (RD + 1) cyc();
      chk("full_drain", 32'(pops - p0), 32'(RD));

      req(1'b0, 2'd2, BASE + 32'd12, 32'h0);
      t_acc = acc_cyc;
      clk_en = 1'b0;
      repeat (3) cyc();
      clk_en = 1'b1;
      wait_rsp();
      chk("en_latency", 32'(pop_cyc - t_acc), 32'(WS + 1));
      trspready = 1'b0;
      req(1'b0, 2'd2, BASE + 32'd16, 32'h0);
      repeat (WS + 1) cyc();
      clk_en = 1'b0; trspready = 1'b1;
      repeat (3) cyc();
      clk_en = 1'b1;
      wait_rsp();

      a0 = accs; p0 = pops;
      trspready = 1'b1; treqvalid = 1'b1; treqdvalid = 1'b0; treqsize = 2'd2;
      for (int i = 0; i < 16; i++) begin
         treqaddr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         cyc();
      end
      treqvalid = 1'b0;
      chk("b2b_accepts", 32'(accs - a0), 32'd16);
      repeat (WS + 1) cyc();
      chk("b2b_pops", 32'(pops - p0), 32'd16);

      trspready = 1'b0; treqvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         treqaddr = BASE + 32'(4 * i);
         cyc();
      end
      resetb = 1'b0;
      cyc();
      chk("midrst_valid", 32'(trspvalid), 32'h0);
      chk("midrst_data", trspdata, 32'h0);
      treqvalid = 1'b0; trspready = 1'b1; resetb = 1'b1;
      repeat (WS + 4) cyc();

      for (int i = 0; i < 400; i++) begin
         treqvalid  = ($urandom_range(0, 3) != 0);
         treqdvalid = 1'($urandom_range(0, 1));
         treqsize   = 2'($urandom_range(0, 3));
         treqaddr   = ($urandom_range(0, 9) != 0) ? BASE + 32'($urandom_range(0, 4 * DEPTH - 1))
                                                  : $urandom();
         treqdata   = $urandom();
         trspready  = ($urandom_range(0, 3) != 0);
         clk_en     = ($urandom_range(0, 7) != 0);
         cyc();
      end
      treqvalid = 1'b0; trspready = 1'b1; clk_en = 1'b1;
      repeat (RD + WS + 3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
